// File: rtl/alu_flag_unit_pkg.sv
// rtl/alu_flag_unit_pkg.sv - shared op codes, FSM encoding and flag helpers for the ALU flag unit
//
// Purpose: constants and helpers shared by alu_flag_unit, its bus interface,
//          the shift-add multiplier and the testbench.
// Ports:   none (package).
package alu_pkg;

    // Operation select encoding, sampled together with start.
    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_SHL = 3'b101;
    localparam logic [2:0] OP_SHR = 3'b110;
    localparam logic [2:0] OP_MUL = 3'b111;

    // Control FSM states.
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_MUL  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // Bit positions inside the {N,C,Z} flag register.
    localparam int FLAG_Z = 0;
    localparam int FLAG_C = 1;
    localparam int FLAG_N = 2;

    // Result of a single-cycle operation before it is registered.
    typedef struct packed {
        logic [7:0] res;
        logic       carry;
    } alu_res_t;

    // Z and N always follow the 8-bit result; only C depends on the op.
    function automatic logic [2:0] make_flags(input logic [7:0] res, input logic carry);
        logic [2:0] f;
        f         = '0;
        f[FLAG_Z] = (res == 8'h00);
        f[FLAG_C] = carry;
        f[FLAG_N] = res[7];
        return f;
    endfunction

endpackage

// File: rtl/alu_flag_unit_if.sv
// rtl/alu_flag_unit_if.sv - operand/handshake/result bundle of the ALU flag unit
//
// Purpose: groups the operand, op select, start/ready/busy/done handshake and
//          result/flag signals between the control sequencer and the ALU.
// Signals: acc_in[7:0]  accumulator operand (A)
//          temp_1[7:0]  TEMP register operand (B, already +1 substituted)
//          op[2:0]      operation select
//          start        execute request
//          ready        unit idle and able to accept start
//          busy         multiply iterating
//          done         one-cycle completion pulse
//          alu_out[7:0] result register
//          flags[2:0]   {N,C,Z}
// Modports: master = sequencer side, slave = ALU side.
interface alu_flag_unit_if;

    logic [7:0] acc_in;
    logic [7:0] temp_1;
    logic [2:0] op;
    logic       start;
    logic       ready;
    logic       busy;
    logic       done;
    logic [7:0] alu_out;
    logic [2:0] flags;

    modport master (
        output acc_in,
        output temp_1,
        output op,
        output start,
        input  ready,
        input  busy,
        input  done,
        input  alu_out,
        input  flags
    );

    modport slave (
        input  acc_in,
        input  temp_1,
        input  op,
        input  start,
        output ready,
        output busy,
        output done,
        output alu_out,
        output flags
    );

endinterface

// File: rtl/alu_flag_unit_shift_add_mul.sv
// rtl/alu_flag_unit_shift_add_mul.sv - iterative unsigned shift-add multiplier
//
// Purpose: one multiplier bit per step; after MUL_CYCLES steps the product
//          holds the unsigned 2*WIDTH-bit result.
// Ports:   clk          clock
//          rst          synchronous active-high reset, clears all state
//          load         capture a (multiplicand) and b (multiplier), clear product
//          a, b         operands
//          step         perform one iteration this cycle
//          product      value the product register takes at this step's edge
//          last         the current step is the final iteration
import alu_pkg::*;

module shift_add_mul #(
    parameter int WIDTH      = 8,
    parameter int MUL_CYCLES = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 load,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    input  logic                 step,
    output logic [2*WIDTH-1:0]   product,
    output logic                 last
);

    localparam int             CW       = (MUL_CYCLES > 1) ? $clog2(MUL_CYCLES) : 1;
    localparam logic [CW-1:0]  LAST_CNT = CW'(MUL_CYCLES - 1);

    logic [WIDTH-1:0]   r_mcand;
    logic [WIDTH-1:0]   r_mplier;
    logic [2*WIDTH-1:0] r_prod;
    logic [CW-1:0]      r_cnt;

    logic [WIDTH:0]     w_upper;
    logic [2*WIDTH-1:0] w_next_prod;

    // Add the multiplicand into the upper half with a carry bit, then shift
    // {carry, product} right by one. Dropping the old LSB is done by taking
    // only r_prod[WIDTH-1:1] rather than building a wider vector.
    always_comb begin
        w_upper     = {1'b0, r_prod[2*WIDTH-1:WIDTH]};
        if (r_mplier[0]) begin
            w_upper = w_upper + {1'b0, r_mcand};
        end
        w_next_prod = {w_upper, r_prod[WIDTH-1:1]};
    end

    // The top registers the result on the same edge as the final step, so it
    // sees the post-step value rather than the stale register.
    assign product = w_next_prod;
    assign last    = (r_cnt == LAST_CNT);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_mcand  <= '0;
            r_mplier <= '0;
            r_prod   <= '0;
            r_cnt    <= '0;
        end else if (load) begin
            r_mcand  <= a;
            r_mplier <= b;
            r_prod   <= '0;
            r_cnt    <= '0;
        end else if (step) begin
            r_prod   <= w_next_prod;
            r_mplier <= r_mplier >> 1;
            r_cnt    <= r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/alu_flag_unit.sv
// rtl/alu_flag_unit.sv - ALU execution stage with result register and Z/C/N flags
//
// Purpose: executes the op selected by the sequencer on acc_in (A) and
//          temp_1 (B). Logic/arith/shift ops finish in one cycle; MUL runs on
//          the shift-add multiplier for MUL_CYCLES cycles.
// Ports:   clk  clock
//          rst  synchronous active-high reset
//          bus  alu_flag_unit_if.slave: acc_in, temp_1, op, start in;
//               ready, busy, done, alu_out, flags out
import alu_pkg::*;

module alu_flag_unit #(
    parameter int WIDTH      = 8,
    parameter int MUL_CYCLES = 8
) (
    input  logic            clk,
    input  logic            rst,
    alu_flag_unit_if.slave  bus
);

    logic [1:0]         r_state;
    logic [WIDTH-1:0]   r_alu_out;
    logic [2:0]         r_flags;

    alu_res_t           w_single;
    logic [WIDTH:0]     w_sum;
    logic [WIDTH:0]     w_diff;
    logic               w_accept;
    logic               w_mul_load;
    logic               w_mul_step;
    logic [2*WIDTH-1:0] w_mul_product;
    logic               w_mul_last;

    // start is only honoured in IDLE; anything else is dropped, not queued.
    assign w_accept   = (r_state == ST_IDLE) && bus.start;
    assign w_mul_load = w_accept && (bus.op == OP_MUL);
    assign w_mul_step = (r_state == ST_MUL);

    // 9-bit add/subtract: bit 8 is the carry out, or for subtraction the
    // unsigned borrow (set exactly when A < B).
    assign w_sum  = {1'b0, bus.acc_in} + {1'b0, bus.temp_1};
    assign w_diff = {1'b0, bus.acc_in} - {1'b0, bus.temp_1};

    always_comb begin
        w_single = '0;
        unique case (bus.op)
            OP_ADD: w_single = '{res: w_sum[7:0],  carry: w_sum[8]};
            OP_SUB: w_single = '{res: w_diff[7:0], carry: w_diff[8]};
            OP_AND: w_single = '{res: bus.acc_in & bus.temp_1, carry: 1'b0};
            OP_OR:  w_single = '{res: bus.acc_in | bus.temp_1, carry: 1'b0};
            OP_XOR: w_single = '{res: bus.acc_in ^ bus.temp_1, carry: 1'b0};
            OP_SHL: w_single = '{res: {bus.acc_in[6:0], 1'b0}, carry: bus.acc_in[7]};
            OP_SHR: w_single = '{res: {1'b0, bus.acc_in[7:1]}, carry: bus.acc_in[0]};
            default: w_single = '0;
        endcase
    end

    shift_add_mul #(
        .WIDTH      (WIDTH),
        .MUL_CYCLES (MUL_CYCLES)
    ) u_mul (
        .clk     (clk),
        .rst     (rst),
        .load    (w_mul_load),
        .a       (bus.acc_in),
        .b       (bus.temp_1),
        .step    (w_mul_step),
        .product (w_mul_product),
        .last    (w_mul_last)
    );

    // Reset zeroes the result and flags too, so a multiply aborted by reset
    // leaves no trace and never produces done.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_alu_out <= '0;
            r_flags   <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        if (bus.op == OP_MUL) begin
                            r_state <= ST_MUL;
                        end else begin
                            r_alu_out <= w_single.res;
                            r_flags   <= make_flags(w_single.res, w_single.carry);
                            r_state   <= ST_DONE;
                        end
                    end
                end
                ST_MUL: begin
                    if (w_mul_last) begin
                        // C reports that the high byte of the product was lost.
                        r_alu_out <= w_mul_product[WIDTH-1:0];
                        r_flags   <= make_flags(w_mul_product[WIDTH-1:0],
                                                |w_mul_product[2*WIDTH-1:WIDTH]);
                        r_state   <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.ready   = (r_state == ST_IDLE);
    assign bus.busy    = (r_state == ST_MUL);
    assign bus.done    = (r_state == ST_DONE);
    assign bus.alu_out = r_alu_out;
    assign bus.flags   = r_flags;

endmodule

// File: tb/tb_alu_flag_unit.sv
// tb/tb_alu_flag_unit.sv - self-checking bench for alu_flag_unit
import alu_pkg::*;

module tb_alu_flag_unit;

    typedef struct {
        logic [2:0] op;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] out;
        logic [2:0] flg;
    } vec_t;

    typedef struct {
        logic [7:0] out;
        logic [2:0] flg;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    alu_flag_unit_if bus();

    alu_flag_unit #(
        .WIDTH      (8),
        .MUL_CYCLES (8)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    exp_t sb[$];
    int   n_pass  = 0;
    int   n_total = 0;
    int   n_done  = 0;
    vec_t vecs[16];

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Scoreboard: every done pulse pops one expected result.
    always @(negedge clk) begin
        if (bus.done) begin : mon
            exp_t e;
            n_done++;
            if (sb.size() == 0) begin
                check("unexpected_done", 16'd1, 16'd0);
            end else begin
                e = sb.pop_front();
                check("alu_out", 16'(bus.alu_out), 16'(e.out));
                check("flags",   16'(bus.flags),   16'(e.flg));
            end
        end
    end

    // Waits for ready, drives start for one cycle, returns at the negedge of
    // the first cycle after the start edge with operands scrambled.
    task automatic issue(input vec_t v, input bit push);
        int guard;
        guard = 0;
        @(negedge clk);
        while (!bus.ready && guard < 30) begin
            @(negedge clk);
            guard++;
        end
        check("ready_before_issue", 16'(bus.ready), 16'd1);
        bus.op     = v.op;
        bus.acc_in = v.a;
        bus.temp_1 = v.b;
        bus.start  = 1'b1;
        if (push) sb.push_back('{out: v.out, flg: v.flg});
        @(negedge clk);
        bus.start  = 1'b0;
        bus.acc_in = 8'($urandom);
        bus.temp_1 = 8'($urandom);
        bus.op     = 3'($urandom);
    endtask

    task automatic wait_done(input vec_t v);
        int lat;
        int nbusy;
        lat   = 1;
        nbusy = 0;
        while (!bus.done && lat < 30) begin
            if (bus.busy) nbusy++;
            @(negedge clk);
            lat++;
        end
        check("latency",     16'(lat),   (v.op == OP_MUL) ? 16'd9 : 16'd1);
        check("busy_cycles", 16'(nbusy), (v.op == OP_MUL) ? 16'd8 : 16'd0);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vec_t m;
        int   lat;
        int   d0;

        vecs[0]  = '{OP_ADD, 8'hFF, 8'h01, 8'h00, 3'b011};
        vecs[1]  = '{OP_SUB, 8'h05, 8'h07, 8'hFE, 3'b110};
        vecs[2]  = '{OP_ADD, 8'h7F, 8'h01, 8'h80, 3'b100};
        vecs[3]  = '{OP_SHR, 8'h81, 8'h5A, 8'h40, 3'b010};
        vecs[4]  = '{OP_MUL, 8'h0C, 8'h0B, 8'h84, 3'b100};
        vecs[5]  = '{OP_MUL, 8'h10, 8'h10, 8'h00, 3'b011};
        vecs[6]  = '{OP_AND, 8'hF0, 8'h3C, 8'h30, 3'b000};
        vecs[7]  = '{OP_OR,  8'h00, 8'h00, 8'h00, 3'b001};
        vecs[8]  = '{OP_XOR, 8'hAA, 8'hAA, 8'h00, 3'b001};
        vecs[9]  = '{OP_XOR, 8'hA5, 8'h0F, 8'hAA, 3'b100};
        vecs[10] = '{OP_SHL, 8'h81, 8'hFF, 8'h02, 3'b010};
        vecs[11] = '{OP_SHL, 8'h40, 8'h00, 8'h80, 3'b100};
        vecs[12] = '{OP_SUB, 8'h07, 8'h07, 8'h00, 3'b001};
        vecs[13] = '{OP_SUB, 8'h07, 8'h05, 8'h02, 3'b000};
        vecs[14] = '{OP_MUL, 8'hFF, 8'hFF, 8'h01, 3'b010};
        vecs[15] = '{OP_ADD, 8'h80, 8'h80, 8'h00, 3'b011};

        bus.start  = 1'b0;
        bus.op     = OP_ADD;
        bus.acc_in = 8'h00;
        bus.temp_1 = 8'h00;
        rst        = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        check("rst_alu_out", 16'(bus.alu_out), 16'h00);
        check("rst_flags",   16'(bus.flags),   16'h0);
        check("rst_ready",   16'(bus.ready),   16'd1);
        check("rst_busy",    16'(bus.busy),    16'd0);
        check("rst_done",    16'(bus.done),    16'd0);

        for (int i = 0; i < 16; i++) begin
            issue(vecs[i], 1'b1);
            wait_done(vecs[i]);
        end

        // start during MUL and during DONE is dropped; start in the next IDLE is taken.
        m = '{OP_MUL, 8'h0C, 8'h0B, 8'h84, 3'b100};
        issue(m, 1'b1);
        lat = 1;
        while (!bus.done && lat < 30) begin
            if (lat == 3) begin
                bus.start  = 1'b1;
                bus.op     = OP_ADD;
                bus.acc_in = 8'h01;
                bus.temp_1 = 8'h01;
            end else begin
                bus.start  = 1'b0;
            end
            @(negedge clk);
            lat++;
        end
        check("mul_latency_with_ignored_start", 16'(lat), 16'd9);
        bus.start  = 1'b1;
        bus.op     = OP_ADD;
        bus.acc_in = 8'h01;
        bus.temp_1 = 8'h02;
        @(negedge clk);
        check("ready_after_done",  16'(bus.ready),   16'd1);
        check("hold_after_done",   16'(bus.alu_out), 16'h84);
        bus.acc_in = 8'h20;
        bus.temp_1 = 8'h03;
        sb.push_back('{out: 8'h23, flg: 3'b000});
        @(negedge clk);
        bus.start = 1'b0;
        check("idle_start_accepted", 16'(bus.done), 16'd1);

        // Reset on the 4th MUL cycle aborts the multiply.
        m = '{OP_MUL, 8'h0C, 8'h0B, 8'h84, 3'b100};
        issue(m, 1'b0);
        repeat (3) @(negedge clk);
        check("busy_before_abort", 16'(bus.busy), 16'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_alu_out", 16'(bus.alu_out), 16'h00);
        check("abort_flags",   16'(bus.flags),   16'h0);
        check("abort_ready",   16'(bus.ready),   16'd1);
        check("abort_busy",    16'(bus.busy),    16'd0);
        d0 = n_done;
        repeat (12) @(negedge clk);
        check("abort_no_done", 16'(n_done - d0), 16'd0);

        // Normal operation resumes after the abort.
        m = '{OP_MUL, 8'h10, 8'h10, 8'h00, 3'b011};
        issue(m, 1'b1);
        wait_done(m);

        repeat (3) @(negedge clk);
        check("scoreboard_empty", 16'(sb.size()), 16'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
